// File: rtl/hazard_ctrl.sv
// Purpose: stall/flush/forward control for the 5-stage pipeline, with a data-memory wait FSM and timeout watchdog.
// Latency: forwarding and stall/flush are combinational from the current inputs and state; hz_state/timeout_err are registered.
// Backpressure: a pending memory access (mem_req_M && !mem_ready_M) freezes F..M until mem_ready_M; HAZARD_PERF_CNT_EN adds perf counters.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_WAIT_MAX   = 15,
    parameter int WAIT_CNT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic [1:0]                ResultSrcE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      PCSrcE,
    input  logic                      mem_req_M,
    input  logic                      mem_ready_M,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic [1:0]                hz_state,
    output logic                      timeout_err,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd3
    } hz_state_e;

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(MEM_WAIT_MAX);

    hz_state_e                 state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      load_use;
    logic                      mem_stall;

    // Forwarding: M beats W, and x0 is never a forwarding source.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    assign load_use  = (ResultSrcE == 2'b01) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = mem_req_M && !mem_ready_M;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushW        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    StallE     = 1'b1;
                    StallM     = 1'b1;
                    FlushW     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_CNT_WIDTH'(1);
                end else if (PCSrcE) begin
                    // The load-use victim sits in D and is being flushed anyway.
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // E is frozen, so a taken branch there is picked up after exit.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
                if (mem_ready_M) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d       = ST_ERROR;
                    timeout_err_d = 1'b1;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
                end
            end

            ST_ERROR: begin
                StallF        = 1'b1;
                StallD        = 1'b1;
                StallE        = 1'b1;
                StallM        = 1'b1;
                FlushW        = 1'b1;
                timeout_err_d = 1'b1;
            end

            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign hz_state    = state_q;
    assign timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (StallF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (FlushD || FlushE) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Generates the stall, flush and forward controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, including the decode→execute register that carries rd1/rd2/RdE/ResultSrcE.
- Sequences multi-cycle data-memory waits through a small FSM, with a timeout watchdog.
- Sits beside the datapath; all pipeline registers take their enable/clear from this block.

Parameters:
- REG_ADDR_WIDTH, 5, width of register specifiers (Rs/Rd).
- MEM_WAIT_MAX, 15, max consecutive memory-wait cycles before timeout.
- WAIT_CNT_WIDTH, 4, width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source regs of the instruction in decode.
- Rs1E, Rs2E  in  REG_ADDR_WIDTH  source regs of the instruction in execute.
- RdE, RdM, RdW  in  REG_ADDR_WIDTH  destination regs in E/M/W.
- ResultSrcE  in  2  result select in E; 2'b01 marks a load.
- RegWriteM, RegWriteW  in  1  write enables in M/W.
- PCSrcE  in  1  taken branch/jump resolved in E.
- mem_req_M  in  1  data-memory access active in M.
- mem_ready_M  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM registers.
- FlushD, FlushE, FlushW  out  1  clear IF-ID / ID-EX / MEM-WB to a bubble.
- ForwardAE, ForwardBE  out  2  ALU operand source: 00 regfile, 10 from M, 01 from W.
- hz_state  out  2  current FSM state.
- timeout_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  32  perf counter (see Optional Feature).
- flush_count  out  32  perf counter (see Optional Feature).

Behaviour:
Reset:
- rst_n low asynchronously sets state=RUN, wait_cnt=0, timeout_err=0, perf counters=0.
- Combinational outputs follow RUN-state equations.

Forwarding (combinational, all states):
- ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
- Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
- Else ForwardAE=00.
- ForwardBE: same rules with Rs2E.
- M has priority over W; x0 is never forwarded.

load_use (combinational):
- ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).

FSM states: RUN=0, MEM_WAIT=1, ERROR=3.
RUN:
- If mem_req_M && !mem_ready_M: StallF=StallD=StallE=StallM=1, FlushW=1; next=MEM_WAIT; wait_cnt<=1.
- Else if PCSrcE: FlushD=FlushE=1, no stalls. Any load_use in the same cycle is suppressed, because the dependent instruction is being flushed.
- Else if load_use: StallF=StallD=1, FlushE=1 (single-cycle bubble, no state change).
- Else all controls 0.

MEM_WAIT:
- StallF/D/E/M=1 and FlushW=1 every cycle.
- PCSrcE is ignored (E is frozen) and is acted on in the RUN cycle after exit.
- On mem_ready_M: next=RUN, wait_cnt<=0. The stalls are still asserted in this cycle; the pipeline advances on the following edge.
- Else if wait_cnt==MEM_WAIT_MAX: next=ERROR, timeout_err<=1.
- Else wait_cnt<=wait_cnt+1, saturating.

ERROR:
- All stalls=1, FlushW=1, timeout_err=1.
- Only rst_n exits this state.

Other rules:
- Reset asserted mid-wait abandons the wait immediately and returns to RUN.
- Stall and flush of the same register are never both 1, except FlushE with StallD on load-use.
- hz_state is registered and reflects the current state.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments in every cycle where StallF=1. flush_count increments in every cycle where FlushD||FlushE=1. Both counters wrap at 2^32 and reset to 0.
- Undefined: no counter flops are built; both ports are tied to 0.

Test Plan:
- Reset release, all inputs 0 → every stall/flush=0, ForwardAE/BE=00, hz_state=0, timeout_err=0.
- RegWriteM=1, RdM=5, Rs1E=5; RegWriteW=1, RdW=5, Rs2E=5 → ForwardAE=10, ForwardBE=01. Repeat with RdM=0 → ForwardAE=00.
- ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly one cycle. Same stimulus with PCSrcE=1 → FlushD=FlushE=1, StallF=0.
- mem_req_M=1, mem_ready_M=0 for 3 cycles, then 1 → stalls high for 4 cycles, hz_state 1→0, timeout_err=0.
- mem_ready_M held 0 → ERROR after MEM_WAIT_MAX+1 wait cycles, timeout_err=1. Assert rst_n=0 mid-ERROR → immediate RUN, timeout_err=0.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 1 branch → stall_cycles=2, flush_count=3. Without the macro → both counters read 0.
